// File: rtl/num_conv_stream.sv
// Streaming two's-complement <-> sign-magnitude converter with valid/ready handshake,
// a small in-order output buffer and a saturating error counter.
module num_conv_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_argA,
  input  logic             i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(DEPTH - 1);
  localparam logic [OccW-1:0]  FullOcc = OccW'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             rdy_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  count_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0] mem_res_q [DEPTH];
  logic             mem_err_q [DEPTH];

  logic             accept, pop;
  logic [WIDTH-1:0] conv_res;
  logic             conv_err;
  logic [WIDTH-1:0] neg_a, neg_mag;

  // Reset release is taken on a clock edge so intake only opens synchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign o_ready = rdy_q & (count_q < FullOcc);
  assign o_valid = (count_q != '0);
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  assign neg_a   = -i_argA;
  assign neg_mag = -{1'b0, i_argA[WIDTH-2:0]};

  always_comb begin
    conv_res = i_argA;
    conv_err = 1'b0;
    if (i_argA[WIDTH-1]) begin
      if (!i_mode) begin
        if (i_argA == MinVal) begin
          // |-2^(W-1)| does not fit in W-1 magnitude bits: saturate.
          conv_res = '1;
          conv_err = 1'b1;
        end else begin
          conv_res = {1'b1, neg_a[WIDTH-2:0]};
        end
      end else begin
        // Negative zero falls out as 0 here.
        conv_res = neg_mag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !accept) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_res_q[wr_ptr_q] <= conv_res;
      mem_err_q[wr_ptr_q] <= conv_err;
    end
  end

  assign o_result = o_valid ? mem_res_q[rd_ptr_q] : '0;
  assign o_error  = o_valid ? mem_err_q[rd_ptr_q] : 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else if (i_clr_cnt) begin
      err_cnt_q <= '0;
    end else if (accept && conv_err && (err_cnt_q != CntMax)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_num_conv_stream.sv
// Scoreboard bench for num_conv_stream: the driver queues expected words on accept and a
// negedge monitor compares every popped buffer head against the queue.
module tb_num_conv_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, o_ready, i_mode, o_valid, i_ready, o_error, i_clr_cnt;
  logic [7:0] i_argA, o_result;
  logic [1:0] o_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb [$];

  num_conv_stream #(
    .WIDTH(8),
    .DEPTH(2),
    .CNT_W(2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_argA   (i_argA),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_error  (o_error),
    .i_clr_cnt(i_clr_cnt),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a head is consumed at the next posedge whenever o_valid & i_ready.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mon_unexpected: got %0h/%0b expected no output", o_result, o_error);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("mon_result", {24'd0, o_result}, {24'd0, e[7:0]});
        check("mon_error", {31'd0, o_error}, {31'd0, e[8]});
      end
    end
  end

  // Drive one word; returns #1 after the accepting edge with i_valid still high.
  task automatic send(input logic [7:0] a, input logic m, input logic [7:0] er,
                      input logic ee, output int waits);
    i_valid = 1'b1;
    i_argA  = a;
    i_mode  = m;
    waits   = 0;
    @(negedge clk);
    while (!o_ready) begin
      waits++;
      if (waits > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no o_ready expected accept of %0h", a);
        i_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb.push_back({ee, er});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
    check("drain_valid", {31'd0, o_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; i_valid = 1'b0; i_argA = '0; i_mode = 1'b0;
    i_ready = 1'b1; i_clr_cnt = 1'b0;
    #12;
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_result", {24'd0, o_result}, 0);
    check("rst_error", {31'd0, o_error}, 0);
    check("rst_errcnt", {30'd0, o_err_cnt}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, o_ready}, 1);

    // Mode 0 basic conversions
    send(8'h05, 1'b0, 8'h05, 1'b0, w);
    send(8'hFB, 1'b0, 8'h85, 1'b0, w);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w);
    i_valid = 1'b0;
    check("m0_errcnt", {30'd0, o_err_cnt}, 1);
    drain();

    // Mode 1 basic conversions, including negative zero
    send(8'h85, 1'b1, 8'hFB, 1'b0, w);
    send(8'h80, 1'b1, 8'h00, 1'b0, w);
    send(8'h7F, 1'b1, 8'h7F, 1'b0, w);
    i_valid = 1'b0;
    drain();
    check("m1_errcnt", {30'd0, o_err_cnt}, 1);

    // Backpressure: third word must be held until downstream drains
    i_ready = 1'b0;
    fork
      begin
        send(8'h01, 1'b0, 8'h01, 1'b0, w);
        send(8'hFF, 1'b0, 8'h81, 1'b0, w);
        send(8'h7F, 1'b0, 8'h7F, 1'b0, w);
        i_valid = 1'b0;
        check("bp_third_stalled", {31'd0, (w >= 3)}, 1);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_ready_low", {31'd0, o_ready}, 0);
        check("bp_valid_high", {31'd0, o_valid}, 1);
        repeat (2) @(negedge clk);
        check("bp_ready_still_low", {31'd0, o_ready}, 0);
        @(posedge clk); #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Full buffer, then continuous push/pop
    i_ready = 1'b0;
    send(8'h81, 1'b1, 8'hFF, 1'b0, w);
    send(8'h01, 1'b1, 8'h01, 1'b0, w);
    i_ready = 1'b1;
    send(8'hFE, 1'b0, 8'h82, 1'b0, w);
    check("full_stall_one", w, 1);
    send(8'h00, 1'b0, 8'h00, 1'b0, w);
    check("stream_nostall_a", w, 0);
    send(8'hFF, 1'b1, 8'h81, 1'b0, w);
    check("stream_nostall_b", w, 0);
    send(8'h90, 1'b0, 8'hF0, 1'b0, w);
    check("stream_nostall_c", w, 0);
    i_valid = 1'b0;
    drain();

    // Error counter saturation and clear priority
    i_clr_cnt = 1'b1;
    @(posedge clk); #1;
    i_clr_cnt = 1'b0;
    check("cnt_cleared", {30'd0, o_err_cnt}, 0);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w); check("cnt_1", {30'd0, o_err_cnt}, 1);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w); check("cnt_2", {30'd0, o_err_cnt}, 2);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w); check("cnt_3", {30'd0, o_err_cnt}, 3);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w); check("cnt_sat_a", {30'd0, o_err_cnt}, 3);
    send(8'h80, 1'b0, 8'hFF, 1'b1, w); check("cnt_sat_b", {30'd0, o_err_cnt}, 3);
    i_clr_cnt = 1'b1;
    send(8'h80, 1'b0, 8'hFF, 1'b1, w);
    i_clr_cnt = 1'b0;
    i_valid = 1'b0;
    check("cnt_clr_prio", {30'd0, o_err_cnt}, 0);
    drain();

    // Asynchronous reset with two words buffered
    i_ready = 1'b0;
    send(8'h80, 1'b0, 8'hFF, 1'b1, w);
    send(8'h10, 1'b1, 8'h10, 1'b0, w);
    i_valid = 1'b0;
    check("pre_rst_errcnt", {30'd0, o_err_cnt}, 1);
    check("pre_rst_valid", {31'd0, o_valid}, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, o_valid}, 0);
    check("mid_rst_result", {24'd0, o_result}, 0);
    check("mid_rst_error", {31'd0, o_error}, 0);
    check("mid_rst_errcnt", {30'd0, o_err_cnt}, 0);
    sb.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, o_ready}, 1);
    check("post_rst_valid", {31'd0, o_valid}, 0);
    i_ready = 1'b1;
    send(8'hC0, 1'b0, 8'hC0, 1'b0, w);
    i_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
